// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the serial pattern-detection controller.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_LEN_W = 8;
   localparam int DEF_CNT_W = 8;

endpackage : seq_det_pkg

// File: rtl/seq_shift_matcher.sv
// Serial history shift register with a saturating bit count and pattern compare.
// hit is combinational and refers to the bit being shifted in this cycle.
module seq_shift_matcher
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             hit
);

   localparam int SW = $clog2(PAT_W + 1);
   localparam logic [SW:0] PAT_LEN = (SW + 1)'(PAT_W);

   logic [PAT_W-1:0] history_q, history_d;
   logic [SW-1:0]    bits_seen_q, bits_seen_d;
   logic [SW:0]      seen_plus1;

   // Compare against the history as it will look after this bit, so a hit
   // can be registered on the same edge that shifts the bit in.
   assign seen_plus1 = {1'b0, bits_seen_q} + (SW + 1)'(1);

   always_comb begin
      history_d   = history_q;
      bits_seen_d = bits_seen_q;
      hit         = 1'b0;
      if (clear) begin
         history_d   = '0;
         bits_seen_d = '0;
      end else if (shift_en) begin
         history_d = {history_q[PAT_W-2:0], bit_in};
         if (seen_plus1 <= PAT_LEN) begin
            bits_seen_d = seen_plus1[SW-1:0];
         end
         hit = (seen_plus1 >= PAT_LEN) && (history_d == pattern);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         history_q   <= '0;
         bits_seen_q <= '0;
      end else begin
         history_q   <= history_d;
         bits_seen_q <= bits_seen_d;
      end
   end

endmodule : seq_shift_matcher

// File: rtl/seq_det_ctrl.sv
// Windowed, counted serial pattern detector: latches a pattern and window
// length on start, counts overlapping hits over that many qualified bits.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int LEN_W = DEF_LEN_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             inp_valid,
   input  logic             inp,
   output logic             busy,
   output logic             match,
   output logic             done,
   output logic [CNT_W-1:0] hit_count,
   output logic             overflow
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic             overflow_q, overflow_d;
   logic             match_q, match_d;
   logic             start_acc;
   logic             shift_en;
   logic             hit;

   seq_shift_matcher #(
      .PAT_W (PAT_W)
   ) u_matcher (
      .clk      (clk),
      .reset    (reset),
      .clear    (start_acc),
      .shift_en (shift_en),
      .bit_in   (inp),
      .pattern  (pattern_q),
      .hit      (hit)
   );

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      remaining_d = remaining_q;
      hit_count_d = hit_count_q;
      overflow_d  = overflow_q;
      match_d     = 1'b0;
      start_acc   = 1'b0;
      shift_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_acc   = 1'b1;
               pattern_d   = cfg_pattern;
               remaining_d = cfg_len;
               hit_count_d = '0;
               overflow_d  = 1'b0;
               state_d     = (cfg_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (inp_valid) begin
               shift_en    = 1'b1;
               remaining_d = remaining_q - LEN_W'(1);
               if (hit) begin
                  match_d = 1'b1;
                  // Counter saturates; the sticky flag records the lost hits.
                  if (&hit_count_q) begin
                     overflow_d = 1'b1;
                  end else begin
                     hit_count_d = hit_count_q + CNT_W'(1);
                  end
               end
               if (remaining_q == LEN_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pattern_q   <= '0;
         remaining_q <= '0;
         hit_count_q <= '0;
         overflow_q  <= 1'b0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         remaining_q <= remaining_d;
         hit_count_q <= hit_count_d;
         overflow_q  <= overflow_d;
         match_q     <= match_d;
      end
   end

   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign done      = (state_q == DONE);
   assign match     = match_q;
   assign hit_count = hit_count_q;
   assign overflow  = overflow_q;

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a 4-bit hit counter so saturation is reachable.
module tb_seq_det_ctrl;

   localparam int PAT_W = 4;
   localparam int LEN_W = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             inp_valid;
   logic             inp;
   logic             busy;
   logic             match;
   logic             done;
   logic [CNT_W-1:0] hit_count;
   logic             overflow;

   int tests_run = 0;
   int fail_cnt  = 0;

   seq_det_ctrl #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .inp_valid   (inp_valid),
      .inp         (inp),
      .busy        (busy),
      .match       (match),
      .done        (done),
      .hit_count   (hit_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, act);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b, input logic v);
      inp       = b;
      inp_valid = v;
      step();
      inp_valid = 1'b0;
   endtask

   task automatic start_win(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len);
      start       = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      step();
      start       = 1'b0;
      cfg_pattern = ~pat;
      cfg_len     = len + LEN_W'(3);
   endtask

   // bits[i] is the i-th bit sent; hitmask[i] marks a hit on that bit.
   task automatic run_window(input string name, input logic [PAT_W-1:0] pat,
                             input int len, input logic [31:0] bits,
                             input logic [31:0] hitmask, input bit gapped,
                             input bit noise);
      int hits = 0;
      start_win(pat, LEN_W'(len));
      check({name, " busy_run"}, 32'(busy), 32'd1);
      for (int i = 0; i < len; i++) begin
         if (noise && (i == 2 || i == 3)) begin
            start       = 1'b1;
            cfg_pattern = ~pat;
            cfg_len     = LEN_W'(3);
         end else begin
            start = 1'b0;
         end
         send(bits[i], 1'b1);
         if (hitmask[i]) hits++;
         check($sformatf("%s match[%0d]", name, i), 32'(match), 32'(hitmask[i]));
         check($sformatf("%s done[%0d]", name, i), 32'(done), 32'(i == len - 1));
         check($sformatf("%s count[%0d]", name, i), 32'(hit_count),
               (hits > 15) ? 32'd15 : 32'(hits));
         check($sformatf("%s ovf[%0d]", name, i), 32'(overflow), 32'(hits >= 16));
         if (gapped && i < len - 1) begin
            send(~bits[i], 1'b0);
            check($sformatf("%s gap_match[%0d]", name, i), 32'(match), 32'd0);
            check($sformatf("%s gap_busy[%0d]", name, i), 32'(busy), 32'd1);
         end
      end
      start = 1'b0;
      check({name, " busy_done"}, 32'(busy), 32'd1);
      step();
      check({name, " busy_idle"}, 32'(busy), 32'd0);
      check({name, " done_idle"}, 32'(done), 32'd0);
      check({name, " match_idle"}, 32'(match), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b1;
      cfg_pattern = 4'b1011;
      cfg_len     = '0;
      inp_valid   = 1'b1;
      inp         = 1'b1;

      // Reset held with start high: everything stays cleared.
      step();
      step();
      check("rst busy", 32'(busy), 32'd0);
      check("rst match", 32'(match), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst count", 32'(hit_count), 32'd0);
      check("rst ovf", 32'(overflow), 32'd0);
      inp_valid = 1'b0;
      reset     = 1'b0;
      step();
      start = 1'b0;
      check("rel start_acc done", 32'(done), 32'd1);
      check("rel start_acc busy", 32'(busy), 32'd1);
      step();
      check("rel idle busy", 32'(busy), 32'd0);

      // Stream 1,0,1,1,0,1,1 (bit0 first) -> hits on bits 4 and 7.
      run_window("overlap", 4'b1011, 7, 32'h6D, 32'h48, 1'b0, 1'b0);
      check("overlap final", 32'(hit_count), 32'd2);

      run_window("gapped", 4'b1011, 7, 32'h6D, 32'h48, 1'b1, 1'b0);
      check("gapped final", 32'(hit_count), 32'd2);

      // 20 ones against 1111: hits on bits 4..20, 17 in total.
      run_window("sat", 4'b1111, 20, 32'hFFFFF, 32'hFFFF8, 1'b0, 1'b0);
      check("sat final count", 32'(hit_count), 32'd15);
      step();
      check("sat ovf sticky", 32'(overflow), 32'd1);

      // Zero-length window clears results and finishes one cycle after start.
      start_win(4'b1011, 8'd0);
      check("len0 done", 32'(done), 32'd1);
      check("len0 busy", 32'(busy), 32'd1);
      check("len0 count", 32'(hit_count), 32'd0);
      check("len0 ovf", 32'(overflow), 32'd0);
      check("len0 match", 32'(match), 32'd0);
      step();
      check("len0 idle done", 32'(done), 32'd0);

      // start pulsed mid-window with a different pattern is ignored.
      run_window("busystart", 4'b1011, 7, 32'h6D, 32'h48, 1'b0, 1'b1);
      check("busystart final", 32'(hit_count), 32'd2);

      // Abort after 1,0,1; the new window must not see the partial history.
      start_win(4'b1011, 8'd7);
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      send(1'b1, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort match", 32'(match), 32'd0);
      check("abort count", 32'(hit_count), 32'd0);
      step();
      check("abort no_done", 32'(done), 32'd0);
      run_window("restart", 4'b1011, 4, 32'hD, 32'h8, 1'b0, 1'b0);
      check("restart final", 32'(hit_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule : tb_seq_det_ctrl
